// File: rtl/shifter_pkg.sv
// Shared types for the ARM operand-2 shifter: shift-type and mode codes plus
// the decoded control word carried from the decode stage to the shift stage.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    MODE_MEM    = 2'b00,
    MODE_IMM    = 2'b01,
    MODE_ISHIFT = 2'b10,
    MODE_RSHIFT = 2'b11
  } mode_t;

  // Immediate LSR #0 / ASR #0 encode a shift of this many bits
  localparam int IMM_ZERO_SHIFT_AMT = 32;

  typedef struct packed {
    mode_t  mode;
    shift_t shType;
    logic   amtZero;
    logic   amtEqW;
    logic   amtGtW;
    logic   rrx;
    logic   carryIn;
  } s1_payload_t;

endpackage

// File: rtl/barrel_rotator.sv
// Combinational rotate-right of a DATA_W vector, built as log2(DATA_W) mux stages.
module barrel_rotator #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]         dataIn,
  input  logic [$clog2(DATA_W)-1:0] amount,
  output logic [DATA_W-1:0]         dataOut
);

  localparam int LOG2W = $clog2(DATA_W);

  logic [DATA_W-1:0] stage [0:LOG2W];

  assign stage[0] = dataIn;

  for (genvar i = 0; i < LOG2W; i++) begin : g_stage
    assign stage[i+1] = amount[i]
      ? {stage[i][(2**i)-1:0], stage[i][DATA_W-1:(2**i)]}
      : stage[i];
  end

  assign dataOut = stage[LOG2W];

endmodule

// File: rtl/operand_shifter.sv
// ARM operand-2 shifter: S1 decodes the request into mode/amount/flags, S2 runs
// one rotator and masks its output to form LSL/LSR/ASR/ROR results and carry.
module operand_shifter #(
  parameter int DATA_W = 32,
  parameter int RS_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] valRm,
  input  logic [RS_W-1:0]   valRs,
  input  logic              imm,
  input  logic              isMem,
  input  logic [11:0]       shiftOperand,
  input  logic              carryIn,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] valOut,
  output logic              carryOut
);

  import shifter_pkg::*;

  localparam int LOG2W = $clog2(DATA_W);
  localparam int AW    = (RS_W > 8) ? RS_W : 8;

  logic              s2Ready;
  logic              s1Valid;
  s1_payload_t       s1Ctl;
  logic [DATA_W-1:0] s1Opnd;
  logic [LOG2W-1:0]  s1Rot;

  s1_payload_t       dCtl;
  logic [DATA_W-1:0] dOpnd;
  logic [LOG2W-1:0]  dRot;
  logic [AW-1:0]     amt;

  logic [LOG2W-1:0]  rotAmt;
  logic [DATA_W-1:0] rotOut;
  logic [DATA_W-1:0] maskL;
  logic [DATA_W-1:0] maskR;
  logic [DATA_W-1:0] nVal;
  logic              nCarry;
  logic              sign;
  logic              over;

  assign s2Ready = !outValid || outReady;
  assign inReady = !s1Valid || s2Ready;

  // Decode: pick the operand and reduce every form to a rotate amount plus flags
  always_comb begin
    dCtl         = '0;
    dOpnd        = valRm;
    dRot         = '0;
    amt          = '0;
    dCtl.carryIn = carryIn;
    dCtl.shType  = shift_t'(shiftOperand[6:5]);
    if (isMem) begin
      dCtl.mode = MODE_MEM;
      dOpnd     = DATA_W'(shiftOperand);
    end else if (imm) begin
      dCtl.mode    = MODE_IMM;
      dOpnd        = DATA_W'(shiftOperand[7:0]);
      dRot         = LOG2W'({shiftOperand[11:8], 1'b0});
      dCtl.amtZero = (shiftOperand[11:8] == 4'd0);
    end else begin
      if (!shiftOperand[4]) begin
        dCtl.mode = MODE_ISHIFT;
        amt       = AW'(shiftOperand[11:7]);
        if (shiftOperand[11:7] == 5'd0) begin
          case (dCtl.shType)
            SH_LSL:  dCtl.amtZero = 1'b1;
            SH_ROR:  dCtl.rrx     = 1'b1;
            default: amt          = AW'(IMM_ZERO_SHIFT_AMT);
          endcase
        end
      end else begin
        dCtl.mode    = MODE_RSHIFT;
        amt          = AW'(valRs);
        dCtl.amtZero = (amt == '0);
      end
      dRot        = amt[LOG2W-1:0];
      dCtl.amtEqW = (amt == AW'(DATA_W));
      dCtl.amtGtW = (amt > AW'(DATA_W));
    end
  end

  // A left shift by n is a right rotate by DATA_W-n with the low bits masked off
  assign rotAmt = ((s1Ctl.mode == MODE_ISHIFT || s1Ctl.mode == MODE_RSHIFT) &&
                   s1Ctl.shType == SH_LSL) ? (LOG2W'(0) - s1Rot) : s1Rot;

  barrel_rotator #(.DATA_W(DATA_W)) u_rotator (
    .dataIn  (s1Opnd),
    .amount  (rotAmt),
    .dataOut (rotOut)
  );

  assign maskL = {DATA_W{1'b1}} << s1Rot;
  assign maskR = {DATA_W{1'b1}} >> s1Rot;
  assign sign  = s1Opnd[DATA_W-1];
  assign over  = s1Ctl.amtEqW | s1Ctl.amtGtW;

  always_comb begin
    nVal   = s1Opnd;
    nCarry = s1Ctl.carryIn;
    case (s1Ctl.mode)
      MODE_MEM: ;
      MODE_IMM: begin
        nVal = rotOut;
        if (!s1Ctl.amtZero) nCarry = rotOut[DATA_W-1];
      end
      default: begin
        if (s1Ctl.rrx) begin
          nVal   = {s1Ctl.carryIn, s1Opnd[DATA_W-1:1]};
          nCarry = s1Opnd[0];
        end else if (!s1Ctl.amtZero) begin
          case (s1Ctl.shType)
            SH_LSL: begin
              if (over) begin
                nVal   = '0;
                nCarry = s1Ctl.amtEqW & s1Opnd[0];
              end else begin
                nVal   = rotOut & maskL;
                nCarry = rotOut[0];
              end
            end
            SH_LSR: begin
              if (over) begin
                nVal   = '0;
                nCarry = s1Ctl.amtEqW & sign;
              end else begin
                nVal   = rotOut & maskR;
                nCarry = rotOut[DATA_W-1];
              end
            end
            SH_ASR: begin
              if (over) begin
                nVal   = {DATA_W{sign}};
                nCarry = sign;
              end else begin
                nVal   = (rotOut & maskR) | (sign ? ~maskR : '0);
                nCarry = rotOut[DATA_W-1];
              end
            end
            default: begin
              nVal   = rotOut;
              nCarry = rotOut[DATA_W-1];
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid  <= 1'b0;
      outValid <= 1'b0;
      valOut   <= '0;
      carryOut <= 1'b0;
    end else begin
      if (inReady) begin
        s1Valid <= inValid;
        if (inValid) begin
          s1Ctl  <= dCtl;
          s1Opnd <= dOpnd;
          s1Rot  <= dRot;
        end
      end
      if (s2Ready) begin
        outValid <= s1Valid;
        if (s1Valid) begin
          valOut   <= nVal;
          carryOut <= nCarry;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_shifter.sv
// Bench for operand_shifter: directed literal cases, a 64-bit instance, stall and
// reset scenarios, then randomized traffic scored against a behavioural model.
module tb_operand_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] valRm = '0;
  logic [7:0]  valRs = '0;
  logic        imm = 1'b0;
  logic        isMem = 1'b0;
  logic [11:0] shiftOperand = '0;
  logic        carryIn = 1'b0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] valOut;
  logic        carryOut;

  logic        w64InValid = 1'b0;
  logic        w64InReady;
  logic [63:0] w64ValRm = '0;
  logic [7:0]  w64ValRs = '0;
  logic        w64Imm = 1'b0;
  logic        w64IsMem = 1'b0;
  logic [11:0] w64ShiftOperand = '0;
  logic        w64CarryIn = 1'b0;
  logic        w64OutValid;
  logic        w64OutReady = 1'b1;
  logic [63:0] w64ValOut;
  logic        w64CarryOut;

  int checks = 0;
  int errors = 0;
  int rxCount = 0;
  int readyMode = 0;
  bit sawStall = 1'b0;
  bit holdPending = 1'b0;
  logic [32:0] heldVal;
  logic [32:0] expQ[$];

  operand_shifter #(.DATA_W(32), .RS_W(8)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .valRm(valRm), .valRs(valRs), .imm(imm), .isMem(isMem),
    .shiftOperand(shiftOperand), .carryIn(carryIn),
    .outValid(outValid), .outReady(outReady), .valOut(valOut), .carryOut(carryOut)
  );

  operand_shifter #(.DATA_W(64), .RS_W(8)) dut64 (
    .clk(clk), .rst(rst), .inValid(w64InValid), .inReady(w64InReady),
    .valRm(w64ValRm), .valRs(w64ValRs), .imm(w64Imm), .isMem(w64IsMem),
    .shiftOperand(w64ShiftOperand), .carryIn(w64CarryIn),
    .outValid(w64OutValid), .outReady(w64OutReady), .valOut(w64ValOut),
    .carryOut(w64CarryOut)
  );

  always #5 clk = ~clk;

  // Reference result {carry, value} for a 32-bit request, straight from the ARM rules
  function automatic logic [32:0] refShift(input logic [31:0] rm, input logic [7:0] rs,
                                           input logic im, input logic mem,
                                           input logic [11:0] so, input logic cin);
    int n;
    int m;
    logic [31:0] v;
    logic c;
    logic [1:0] t;
    v = '0;
    c = 1'b0;
    t = so[6:5];
    if (mem) return {cin, 20'b0, so};
    if (im) begin
      n = 2 * int'(so[11:8]);
      v = {24'b0, so[7:0]};
      if (n != 0) v = (v >> n) | (v << (32 - n));
      c = (n == 0) ? cin : v[31];
      return {c, v};
    end
    if (!so[4]) begin
      n = int'(so[11:7]);
      if (n == 0) begin
        case (t)
          2'd0: return {cin, rm};
          2'd3: return {rm[0], cin, rm[31:1]};
          default: n = 32;
        endcase
      end
    end else begin
      n = int'(rs);
      if (n == 0) return {cin, rm};
    end
    case (t)
      2'd0: begin
        if (n < 32) begin v = rm << n; c = rm[32-n]; end
        else if (n == 32) begin v = '0; c = rm[0]; end
        else begin v = '0; c = 1'b0; end
      end
      2'd1: begin
        if (n < 32) begin v = rm >> n; c = rm[n-1]; end
        else if (n == 32) begin v = '0; c = rm[31]; end
        else begin v = '0; c = 1'b0; end
      end
      2'd2: begin
        if (n >= 32) begin v = {32{rm[31]}}; c = rm[31]; end
        else begin v = $signed(rm) >>> n; c = rm[n-1]; end
      end
      default: begin
        m = n % 32;
        if (m == 0) begin v = rm; c = rm[31]; end
        else begin v = (rm >> m) | (rm << (32 - m)); c = rm[m-1]; end
      end
    endcase
    return {c, v};
  endfunction

  task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request and hold it until the DUT accepts it (bounded)
  task automatic applyStimulus(input logic [31:0] rm, input logic [7:0] rs, input logic im,
                               input logic mem, input logic [11:0] so, input logic cin);
    bit done;
    bit rdy;
    done = 1'b0;
    valRm = rm; valRs = rs; imm = im; isMem = mem; shiftOperand = so; carryIn = cin;
    inValid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      rdy = inReady;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: request not accepted within 100 cycles");
    end
    inValid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (expQ.size() == 0 && !outValid) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", 65'(expQ.size() != 0 || outValid), 65'd0);
  endtask

  task automatic directed32(input string name, input logic [31:0] rm, input logic [7:0] rs,
                            input logic im, input logic mem, input logic [11:0] so,
                            input logic cin, input logic [31:0] expV, input logic expC);
    drain();
    applyStimulus(rm, rs, im, mem, so, cin);
    @(posedge clk);
    #1;
    checkOutput(name, 65'({outValid, carryOut, valOut}), 65'({1'b1, expC, expV}));
  endtask

  task automatic run64(input string name, input logic [63:0] rm, input logic [7:0] rs,
                       input logic im, input logic mem, input logic [11:0] so, input logic cin,
                       input logic [63:0] expV, input logic expC);
    int lat;
    w64ValRm = rm; w64ValRs = rs; w64Imm = im; w64IsMem = mem;
    w64ShiftOperand = so; w64CarryIn = cin; w64InValid = 1'b1;
    checkOutput({name, "_inready"}, 65'(w64InReady), 65'd1);
    @(posedge clk);
    #1;
    w64InValid = 1'b0;
    lat = 1;
    while (!w64OutValid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput(name, {w64CarryOut, w64ValOut}, {expC, expV});
    checkOutput({name, "_latency"}, 65'(lat), 65'd2);
  endtask

  function automatic logic [7:0] pickRs();
    case ($urandom_range(0, 7))
      0: return 8'd0;
      1: return 8'd32;
      2: return 8'd33;
      3: return 8'd255;
      4: return 8'($urandom_range(1, 31));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: outReady = 1'b1;
      1: outReady = ($urandom_range(0, 3) != 0);
      default: outReady = 1'b0;
    endcase
  end

  // Scoreboard: drains before accepts so a same-cycle push is never compared early
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        checkOutput("hold_stable", 65'({outValid, carryOut, valOut}), 65'({1'b1, heldVal}));
      end
      if (outValid && outReady) begin
        rxCount++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got %h expected none", {carryOut, valOut});
        end else begin
          checkOutput("result", 65'({carryOut, valOut}), 65'(expQ.pop_front()));
        end
      end
      if (!outValid) checkOutput("inready_empty_out", 65'(inReady), 65'd1);
      holdPending = outValid && !outReady;
      heldVal = {carryOut, valOut};
      if (inValid && inReady) expQ.push_back(refShift(valRm, valRs, imm, isMem, shiftOperand, carryIn));
      if (inValid && !inReady) sawStall = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int rxBefore;
    int r;
    logic [11:0] so;
    logic [31:0] rm;

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 65'({outValid, carryOut, valOut}), 65'd0);
    checkOutput("reset_state_64", {w64CarryOut, w64ValOut}, 65'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset_inready", 65'(inReady), 65'd1);

    checkOutput("model_imm", 65'(refShift(32'h0, 8'd0, 1'b1, 1'b0, 12'h4FF, 1'b0)), 65'({1'b1, 32'hFF000000}));
    checkOutput("model_rrx", 65'(refShift(32'h3, 8'd0, 1'b0, 1'b0, 12'h060, 1'b1)), 65'({1'b1, 32'h80000001}));
    checkOutput("model_asr0", 65'(refShift(32'h80000000, 8'd0, 1'b0, 1'b0, 12'h040, 1'b0)), 65'({1'b1, 32'hFFFFFFFF}));
    checkOutput("model_lsr32", 65'(refShift(32'h80000001, 8'd32, 1'b0, 1'b0, 12'h030, 1'b0)), 65'({1'b1, 32'h0}));
    checkOutput("model_lsl4", 65'(refShift(32'h1000000F, 8'd4, 1'b0, 1'b0, 12'h010, 1'b0)), 65'({1'b1, 32'h000000F0}));

    readyMode = 0;
    directed32("imm_rotate", 32'h0, 8'd0, 1'b1, 1'b0, 12'h4FF, 1'b0, 32'hFF000000, 1'b1);
    directed32("imm_rrx", 32'h3, 8'd0, 1'b0, 1'b0, 12'h060, 1'b1, 32'h80000001, 1'b1);
    directed32("imm_asr0", 32'h80000000, 8'd0, 1'b0, 1'b0, 12'h040, 1'b0, 32'hFFFFFFFF, 1'b1);
    directed32("reg_lsr32", 32'h80000001, 8'd32, 1'b0, 1'b0, 12'h030, 1'b0, 32'h0, 1'b1);
    directed32("reg_lsr40", 32'h80000001, 8'd40, 1'b0, 1'b0, 12'h030, 1'b0, 32'h0, 1'b0);
    directed32("mem_offset", 32'hDEADBEEF, 8'd7, 1'b0, 1'b1, 12'hABC, 1'b1, 32'h00000ABC, 1'b1);
    directed32("reg_ror32", 32'h80000001, 8'd32, 1'b0, 1'b0, 12'h070, 1'b0, 32'h80000001, 1'b1);

    $display("[TB] 64-bit instance");
    run64("w64_lsl64", 64'h1, 8'd64, 1'b0, 1'b0, 12'h010, 1'b0, 64'h0, 1'b1);
    run64("w64_lsr33", 64'h8000_0001_0000_0000, 8'd33, 1'b0, 1'b0, 12'h030, 1'b0, 64'h4000_0000, 1'b1);
    run64("w64_asr0", 64'h8000_0000_0000_0000, 8'd0, 1'b0, 1'b0, 12'h040, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0);
    run64("w64_imm", 64'h0, 8'd0, 1'b1, 1'b0, 12'h4FF, 1'b0, 64'hFF00_0000_0000_0000, 1'b1);
    run64("w64_asr70", 64'h8000_0000_0000_0000, 8'd70, 1'b0, 1'b0, 12'h050, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run64("w64_ror64", 64'h8000_0000_0000_0001, 8'd64, 1'b0, 1'b0, 12'h070, 1'b0, 64'h8000_0000_0000_0001, 1'b1);

    $display("[TB] stalled stream");
    drain();
    sawStall = 1'b0;
    rxBefore = rxCount;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          so = 12'($urandom);
          so[4] = 1'b1;
          applyStimulus($urandom, pickRs(), 1'b0, 1'b0, so, 1'($urandom));
        end
      end
      begin
        repeat (2) @(posedge clk);
        readyMode = 2;
        repeat (3) @(posedge clk);
        readyMode = 0;
      end
    join
    drain();
    checkOutput("stream_stall_seen", 65'(sawStall), 65'd1);
    checkOutput("stream_count", 65'(rxCount - rxBefore), 65'd8);

    $display("[TB] reset with requests in flight");
    readyMode = 2;
    @(posedge clk);
    #2;
    applyStimulus(32'h12345678, 8'd4, 1'b0, 1'b0, 12'h010, 1'b0);
    applyStimulus(32'h87654321, 8'd8, 1'b0, 1'b0, 12'h030, 1'b1);
    rxBefore = rxCount;
    rst = 1'b1;
    valRm = 32'hFFFFFFFF; shiftOperand = 12'h0FF; imm = 1'b1; isMem = 1'b0; inValid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    inValid = 1'b0;
    checkOutput("reset_flush", 65'({outValid, carryOut, valOut}), 65'd0);
    checkOutput("reset_flush_inready", 65'(inReady), 65'd1);
    readyMode = 0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("reset_no_result", 65'(rxCount - rxBefore), 65'd0);

    $display("[TB] random traffic");
    readyMode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      r = $urandom_range(0, 9);
      so = 12'($urandom);
      rm = $urandom;
      if ($urandom_range(0, 3) == 0) rm = {1'b1, 31'($urandom_range(0, 3))};
      if (r >= 3) so[4] = (r >= 6);
      applyStimulus(rm, pickRs(), (r == 1 || r == 2), (r == 0), so, 1'($urandom));
    end
    readyMode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_shifter.md
OPERAND_SHIFTER -- requirements
Module: operand_shifter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width in bits (legal values: 32, 64).
REQ-002 SHALL have parameter RS_W, default 8, width of the register-specified shift amount.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port inValid  input  1  request present.
REQ-006 SHALL have port inReady  output  1  request accepted when inValid && inReady at a clk edge.
REQ-007 SHALL have port valRm  input  DATA_W  operand to shift.
REQ-008 SHALL have port valRs  input  RS_W  register shift amount, unsigned.
REQ-009 SHALL have port imm  input  1  immediate-rotate form.
REQ-010 SHALL have port isMem  input  1  memory-offset form.
REQ-011 SHALL have port shiftOperand  input  12  ARM operand-2 field.
REQ-012 SHALL have port carryIn  input  1  current C flag.
REQ-013 SHALL have port outValid  output  1  result present.
REQ-014 SHALL have port outReady  input  1  consumer accepts the result when outValid && outReady.
REQ-015 SHALL have port valOut  output  DATA_W  shifted operand.
REQ-016 SHALL have port carryOut  output  1  shifter carry-out.

Function
REQ-017 Mode priority SHALL be: isMem > imm > shiftOperand[4]=0 (immediate shift) > shiftOperand[4]=1 (register shift).
REQ-018 isMem: valOut = zero-extended shiftOperand; carryOut = carryIn.
REQ-019 imm: valOut = zero-extended shiftOperand[7:0] rotated right by 2*shiftOperand[11:8] modulo DATA_W; carryOut = carryIn if the rotate is 0, else valOut[DATA_W-1].
REQ-020 Immediate shift: amount = shiftOperand[11:7]; type = shiftOperand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
REQ-021 Immediate shift special encodings: LSL #0 passes valRm with carryOut = carryIn; LSR #0 and ASR #0 mean a shift of 32; ROR #0 means RRX (valOut = {carryIn, valRm[DATA_W-1:1]}, carryOut = valRm[0]).
REQ-022 Register shift: amount = valRs; type = shiftOperand[6:5]; amount 0 passes valRm with carryOut = carryIn for every type.
REQ-023 Register LSL/LSR: amount < DATA_W gives the normal shift, carryOut = the last bit shifted out; amount = DATA_W gives 0 with carryOut = valRm[0] (LSL) or valRm[DATA_W-1] (LSR); amount > DATA_W gives 0 with carryOut = 0.
REQ-024 Register ASR with amount >= DATA_W: every valOut bit = valRm[DATA_W-1]; carryOut = valRm[DATA_W-1].
REQ-025 Register ROR: rotate by amount mod DATA_W; if that is 0 with amount != 0, valOut = valRm and carryOut = valRm[DATA_W-1].
REQ-026 Normal shifts with 0 < n < DATA_W SHALL give carryOut: LSL valRm[DATA_W-n]; LSR/ASR/ROR valRm[n-1].
REQ-027 Pipeline SHALL be two registered stages: S1 captures decoded mode, type, amount, special-case flags, valRm and carryIn; S2 captures valOut and carryOut.
REQ-028 Latency SHALL be exactly 2 cycles from acceptance to outValid when not stalled; throughput 1 result per cycle.
REQ-029 inReady = !s1Valid || s2Ready; s2Ready = !outValid || outReady; both combinational, with no dependence on inValid.
REQ-030 While outValid && !outReady, valOut, carryOut and outValid SHALL hold stable.
REQ-031 A simultaneous accept and drain on the same edge SHALL advance all stages with no bubble and no loss.
REQ-032 Results SHALL leave in acceptance order; no request is dropped or duplicated.

Reset
REQ-033 With rst high at a clk edge, s1Valid, outValid, valOut and carryOut SHALL be 0 on the next cycle; inReady SHALL be 1 while rst is low and the pipeline is empty.
REQ-034 Reset mid-operation SHALL discard all in-flight requests; nothing is accepted on a cycle where rst is high.

Structure
REQ-035 Package shifter_pkg SHALL hold the shift-type codes (LSL/LSR/ASR/ROR), mode codes (MEM/IMM/ISHIFT/RSHIFT) and the S1 payload struct.
REQ-036 One sub-module, barrel_rotator (parametrised combinational rotate-right by DATA_W), SHALL be instantiated in S2; LSL/LSR/ASR are derived from its output with masks.

Verification
REQ-037 imm=1, shiftOperand=12'h4FF, carryIn=0 -> valOut=32'hFF000000, carryOut=1, after 2 cycles.
REQ-038 Immediate ROR #0 (RRX), valRm=32'h00000003, carryIn=1 -> valOut=32'h80000001, carryOut=1.
REQ-039 Immediate ASR #0, valRm=32'h80000000 -> valOut=32'hFFFFFFFF, carryOut=1; register LSR, valRs=32, valRm=32'h80000001 -> valOut=0, carryOut=1; valRs=40 -> valOut=0, carryOut=0.
REQ-040 Back-to-back stream of 8 requests with outReady held low for cycles 3-5 -> inReady drops once both stages are full, outputs stay stable, all 8 results arrive in order and correct.
REQ-041 rst asserted while 2 requests are in flight -> outValid=0, valOut=0 next cycle; neither result ever appears.
REQ-042 DATA_W=64, register LSL, valRs=64, valRm=1 -> valOut=0, carryOut=1.
